// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit 7-segment scan back into four hex digits.
// Define SEG_ERR_EN to reject frames containing unmatched segment patterns (code_err pulse).
module seg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   input  logic [3:0] anode_sig,
   output logic [3:0] output1,
   output logic [3:0] output2,
   output logic [3:0] output3,
   output logic [3:0] output4,
   output logic       frame_valid,
   output logic       code_err
);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

   localparam logic [8:0] SETTLE_LIMIT = 9'(SETTLE_CYCLES);

   function automatic logic is_onehot_low(input logic [3:0] v);
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // Slot 0 is the leftmost digit, driven by anode_sig[3].
   function automatic logic [1:0] slot_index(input logic [3:0] v);
      case (v)
         4'b0111: return 2'd0;
         4'b1011: return 2'd1;
         4'b1101: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] decode_seg(input logic [6:0] p);
      case (p)
         7'b0000001: return 4'h0;
         7'b1001111: return 4'h1;
         7'b0010010: return 4'h2;
         7'b0000110: return 4'h3;
         7'b1001100: return 4'h4;
         7'b0100100: return 4'h5;
         7'b0100000: return 4'h6;
         7'b0001111: return 4'h7;
         7'b0000000: return 4'h8;
         7'b0000100: return 4'h9;
         7'b0001000: return 4'hA;
         7'b1100000: return 4'hB;
         7'b0110001: return 4'hC;
         7'b1000010: return 4'hD;
         7'b0110000: return 4'hE;
         7'b0111000: return 4'hF;
         default:    return 4'h0;
      endcase
   endfunction

`ifdef SEG_ERR_EN
   function automatic logic seg_matched(input logic [6:0] p);
      case (p)
         7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
         7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
         7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction
`endif

   state_t     state;
   state_t     state_next;
   logic [7:0] cnt;
   logic [7:0] cnt_next;
   logic       do_capture;
   logic [6:0] seg;
   logic [6:0] prev_seg;
   logic [3:0] prev_anode;
   logic       anode_changed;
   logic       pattern_changed;
   logic [1:0] capture_idx;
   logic [3:0] slots [4];
   logic [3:0] captured;
`ifdef SEG_ERR_EN
   logic [3:0] unmatched;
`endif

   assign seg             = {a, b, c, d, e, f, g};
   assign anode_changed   = (anode_sig != prev_anode);
   assign pattern_changed = anode_changed || (seg != prev_seg);
   assign capture_idx     = slot_index(prev_anode);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // CAPTURE also watches the anode so a digit change on the capture cycle is not lost.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      do_capture = 1'b0;
      case (state)
         IDLE: begin
            if (is_onehot_low(anode_sig)) begin
               state_next = SETTLE;
               cnt_next   = 8'd1;
            end
         end
         SETTLE: begin
            if (!is_onehot_low(anode_sig)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (pattern_changed) begin
               cnt_next = 8'd1;
            end else if (({1'b0, cnt} + 9'd1) >= SETTLE_LIMIT) begin
               state_next = CAPTURE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         CAPTURE, HOLD: begin
            do_capture = (state == CAPTURE);
            if (anode_changed) begin
               if (is_onehot_low(anode_sig)) begin
                  state_next = SETTLE;
                  cnt_next   = 8'd1;
               end else begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               state_next = HOLD;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      if (SETTLE_CYCLES <= 1 && state_next == SETTLE) begin
         state_next = CAPTURE;
         cnt_next   = '0;
      end
   end

   // Completion and a new capture may share a cycle; the new capture's bit survives the clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         prev_anode  <= 4'hF;
         prev_seg    <= 7'h7F;
         captured    <= '0;
         output1     <= '0;
         output2     <= '0;
         output3     <= '0;
         output4     <= '0;
         frame_valid <= 1'b0;
         for (int i = 0; i < 4; i++) slots[i] <= '0;
`ifdef SEG_ERR_EN
         unmatched   <= '0;
         code_err    <= 1'b0;
`endif
      end else begin
         prev_anode  <= anode_sig;
         prev_seg    <= seg;
         frame_valid <= 1'b0;
`ifdef SEG_ERR_EN
         code_err    <= 1'b0;
`endif
         if (&captured) begin
            captured <= '0;
`ifdef SEG_ERR_EN
            unmatched <= '0;
            if (|unmatched) begin
               code_err <= 1'b1;
            end else begin
               output1     <= slots[0];
               output2     <= slots[1];
               output3     <= slots[2];
               output4     <= slots[3];
               frame_valid <= 1'b1;
            end
`else
            output1     <= slots[0];
            output2     <= slots[1];
            output3     <= slots[2];
            output4     <= slots[3];
            frame_valid <= 1'b1;
`endif
         end
         if (do_capture) begin
            slots[capture_idx]    <= decode_seg(prev_seg);
            captured[capture_idx] <= 1'b1;
`ifdef SEG_ERR_EN
            unmatched[capture_idx] <= ~seg_matched(prev_seg);
`endif
         end
      end
   end

`ifndef SEG_ERR_EN
   assign code_err = 1'b0;
`endif

endmodule
